i2s_stream_tx: RTL and testbench

- Parametrised next-generation I2S audio transmitter for the MAX10 audio path.
- Accepts stereo sample pairs over a valid/ready stream from the effects pipeline and buffers them in a small synchronous FIFO.
- Serialises each pair onto mclk/bclk/lrclk/sdata from the 50 MHz system clock.
- Adds mono duplication, mute, offset-binary output format, underflow handling and FIFO level reporting.

---
 rtl/i2s_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/i2s_stream_tx.sv | 146 ++++++++++++++
 tb/tb_i2s_stream_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and the output-format helper for the I2S transmit path.
// fmt_sample works on a wide container so any instance width up to SAMPLE_W_MAX can use it.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int SAMPLE_W_MAX = 32;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } frame_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } lr_slot_e;

  // Offset-binary flips the sample MSB; mute wins over everything.
  function automatic logic [SAMPLE_W_MAX-1:0] fmt_sample(
    input logic [SAMPLE_W_MAX-1:0] sample,
    input int unsigned             width,
    input logic                    offset_bin,
    input logic                    mute
  );
    logic [SAMPLE_W_MAX-1:0] flip;
    flip = {{(SAMPLE_W_MAX-1){1'b0}}, offset_bin} << (width - 1);
    return mute ? '0 : (sample ^ flip);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty/level.
// A write while full is accepted when a read happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    level_nxt = level;
    if (do_wr && !do_rd) begin
      level_nxt = level + LVL_W'(1);
    end else if (!do_wr && do_rd) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/i2s_stream_tx.sv
// I2S transmitter: buffers stereo pairs from a valid/ready stream and serialises
// them on mclk/bclk/lrclk/sdata, one frame of 2*SLOT_BITS bit clocks per pair.
module i2s_stream_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_BITS  = 32,
  parameter int MCLK_DIV   = 4,
  parameter int BCLK_DIV   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SAMPLE_W-1:0]             in_left,
  input  logic [SAMPLE_W-1:0]             in_right,
  input  logic                            mono,
  input  logic                            mute,
  input  logic                            offset_bin,
  output logic                            mclk,
  output logic                            bclk,
  output logic                            lrclk,
  output logic                            sdata,
  output logic                            underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int MC_W = $clog2(MCLK_DIV);
  localparam int BC_W = $clog2(BCLK_DIV);
  localparam int BI_W = $clog2(2 * SLOT_BITS);

  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MCLK_DIV - 1);
  localparam logic [MC_W-1:0] MC_HALF = MC_W'(MCLK_DIV / 2);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_HALF = BC_W'(BCLK_DIV / 2);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(2 * SLOT_BITS - 1);
  localparam logic [BI_W-1:0] BI_SLOT = BI_W'(SLOT_BITS);

  // Same layout as i2s_pkg::frame_t, sized by this instance.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [MC_W-1:0]     mc, mc_nxt;
  logic [BC_W-1:0]     bc, bc_nxt;
  logic [BI_W-1:0]     bidx, bidx_nxt;
  logic [BI_W-1:0]     pos_nxt;
  logic                tick;
  logic                load;
  logic                load_nxt;
  logic                load_pend;
  lr_slot_e            slot_nxt;
  logic [SAMPLE_W-1:0] chan;
  logic                bit_nxt;

  pair_t               head;
  pair_t               frame;
  logic                armed;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  assign mc_nxt   = (mc == MC_LAST) ? '0 : mc + MC_W'(1);
  assign bc_nxt   = (bc == BC_LAST) ? '0 : bc + BC_W'(1);
  assign tick     = (bc == BC_LAST);
  assign load     = tick && (bidx == BI_LAST);
  assign bidx_nxt = !tick ? bidx : ((bidx == BI_LAST) ? '0 : bidx + BI_W'(1));
  assign load_nxt = (bc_nxt == BC_LAST) && (bidx_nxt == BI_LAST);

  // Slot position 0 is the I2S one-bit delay; positions past SAMPLE_W pad with zero.
  always_comb begin
    slot_nxt = (bidx_nxt >= BI_SLOT) ? RIGHT : LEFT;
    pos_nxt  = (slot_nxt == RIGHT) ? bidx_nxt - BI_SLOT : bidx_nxt;
    chan     = (slot_nxt == RIGHT) ? frame.right : frame.left;
    bit_nxt  = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (pos_nxt == BI_W'(SAMPLE_W - i)) bit_nxt = chan[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc        <= '0;
      bc        <= '0;
      bidx      <= '0;
      mclk      <= 1'b0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      mc        <= mc_nxt;
      bc        <= bc_nxt;
      bidx      <= bidx_nxt;
      mclk      <= (mc_nxt >= MC_HALF);
      bclk      <= (bc_nxt >= BC_HALF);
      load_pend <= load_nxt;
      if (tick) begin
        lrclk <= (slot_nxt == RIGHT);
        sdata <= bit_nxt;
      end
    end
  end

  // A full FIFO still takes a pair on the frame-load cycle, where a pop is
  // certain; both terms are registered so pop never reaches in_ready.
  assign in_ready = !fifo_full || load_pend;
  assign push     = in_valid && in_ready;
  assign pop      = load && !fifo_empty;

  sync_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({in_left, in_right}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame     <= '0;
      armed     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= load && fifo_empty && armed;
      if (pop) begin
        frame.left  <= SAMPLE_W'(fmt_sample(SAMPLE_W_MAX'(head.left), SAMPLE_W,
                                            offset_bin, mute));
        frame.right <= SAMPLE_W'(fmt_sample(SAMPLE_W_MAX'(mono ? head.left : head.right),
                                            SAMPLE_W, offset_bin, mute));
        armed       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_tx.sv
// Randomised bench for i2s_stream_tx against a frame-level model: clock phases
// and slot bits are derived from the edge count since reset, the FIFO is a queue.
module tb_i2s_stream_tx;
  import i2s_pkg::*;

  localparam int SW    = 16;
  localparam int SLOT  = 32;
  localparam int MDIV  = 4;
  localparam int BDIV  = 16;
  localparam int DEPTH = 8;
  localparam int FRAME = 2 * SLOT * BDIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_left = '0;
  logic [SW-1:0] in_right = '0;
  logic          mono = 1'b0;
  logic          mute = 1'b0;
  logic          offset_bin = 1'b0;
  logic          mclk, bclk, lrclk, sdata, underflow;
  logic [3:0]    fifo_level;

  always #10 clk = ~clk;

  i2s_stream_tx #(
    .SAMPLE_W   (SW),
    .SLOT_BITS  (SLOT),
    .MCLK_DIV   (MDIV),
    .BCLK_DIV   (BDIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .mono       (mono),
    .mute       (mute),
    .offset_bin (offset_bin),
    .mclk       (mclk),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .underflow  (underflow),
    .fifo_level (fifo_level)
  );

  int     vectors = 0;
  int     miscompares = 0;

  // Model state: n = rising edges since reset released.
  int     n = 0;
  frame_t q[$];
  frame_t cur = '0;
  bit     armed_m = 1'b0;
  bit     uf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic bit ready_m();
    return (q.size() < DEPTH) || (((n + 1) % FRAME) == 0);
  endfunction

  function automatic bit exp_sdata();
    int b;
    int p;
    logic [SW-1:0] ch;
    b  = (n / BDIV) % (2 * SLOT);
    p  = b % SLOT;
    ch = (b >= SLOT) ? cur.right : cur.left;
    if (p >= 1 && p <= SW) return ch[SW-p];
    return 1'b0;
  endfunction

  task automatic check_outputs();
    chk("mclk",       mclk,       32'((n % MDIV) >= MDIV / 2));
    chk("bclk",       bclk,       32'((n % BDIV) >= BDIV / 2));
    chk("lrclk",      lrclk,      32'(((n / BDIV) % (2 * SLOT)) >= SLOT));
    chk("sdata",      sdata,      32'(exp_sdata()));
    chk("underflow",  underflow,  32'(uf_m));
    chk("fifo_level", fifo_level, 32'(q.size()));
    chk("in_ready",   in_ready,   32'(ready_m()));
  endtask

  function automatic void model_step(input bit r, input bit v,
                                     input logic [SW-1:0] l, input logic [SW-1:0] rv);
    bit            rdy;
    frame_t        h;
    logic [SW-1:0] a;
    logic [SW-1:0] b;
    if (r) begin
      n = 0;
      q.delete();
      cur = '0;
      armed_m = 1'b0;
      uf_m = 1'b0;
      return;
    end
    rdy = ready_m();
    n++;
    uf_m = 1'b0;
    if ((n % FRAME) == 0) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        a = h.left;
        b = mono ? h.left : h.right;
        if (offset_bin) begin
          a = a ^ 16'h8000;
          b = b ^ 16'h8000;
        end
        if (mute) begin
          a = '0;
          b = '0;
        end
        cur.left  = a;
        cur.right = b;
        armed_m   = 1'b1;
      end else if (armed_m) begin
        uf_m = 1'b1;
      end
    end
    if (v && rdy) q.push_back('{left: l, right: rv});
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [SW-1:0] l, input logic [SW-1:0] rv);
    check_outputs();
    rst      = r;
    in_valid = v;
    in_left  = l;
    in_right = rv;
    model_step(r, v, l, rv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_until(input int target);
    while (n < target) cyc(1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    int            pushed;
    bit            acc;
    int            prob;
    logic [SW-1:0] l;
    logic [SW-1:0] r;

    repeat (3) @(posedge clk);
    @(negedge clk);

    // Idle after reset: clocks only, silent data, no underflow.
    idle_until(3 * FRAME);

    // One pair before a frame load, then starve: replayed frame with underflow pulses.
    cyc(1'b0, 1'b1, 16'h8001, 16'h7FFE);
    idle_until(6 * FRAME + 10);

    // Mono + offset-binary on the same pair.
    mono = 1'b1;
    offset_bin = 1'b1;
    cyc(1'b0, 1'b1, 16'h8001, 16'h7FFE);
    idle_until(8 * FRAME + 10);
    mono = 1'b0;
    offset_bin = 1'b0;

    // Nine back-to-back pairs; the ninth is held until the model says it is taken.
    pushed = 0;
    l = 16'($urandom);
    r = 16'($urandom);
    while (pushed < DEPTH + 1) begin
      acc = ready_m();
      cyc(1'b0, 1'b1, l, r);
      if (acc) begin
        pushed++;
        l = 16'($urandom);
        r = 16'($urandom);
      end
    end
    idle_until(n + 2 * FRAME);

    // Random traffic density and format flags, one setting per frame.
    for (int f = 0; f < 6; f++) begin
      prob       = $urandom_range(1, 40);
      mono       = 1'($urandom_range(0, 1));
      mute       = 1'($urandom_range(0, 3) == 0);
      offset_bin = 1'($urandom_range(0, 1));
      for (int c = 0; c < FRAME; c++) begin
        cyc(1'b0, $urandom_range(0, prob) == 0, 16'($urandom), 16'($urandom));
      end
    end
    mono = 1'b0;
    mute = 1'b0;
    offset_bin = 1'b0;

    // Reset mid-frame with entries queued; restart must look like power-up.
    cyc(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    idle_until(20 * BDIV + 5);
    cyc(1'b1, 1'b0, '0, '0);
    idle_until(2 * FRAME + 20);

    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
